// File: rtl/alu_result_stage_pkg.sv
// rtl/alu_result_stage_pkg.sv - shared types and constants for the ALU result stage
package alu_result_stage_pkg;

  // Default data and select widths; they match the result mux output.
  localparam int ALU_WIDTH = 16;
  localparam int ALU_SELW  = 3;

  // Bit positions inside the 4-bit status flag vector {C,P,N,Z}.
  localparam int FLAGW  = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_P = 2;
  localparam int FLAG_C = 3;

  // Occupancy of the head/skid pair.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  // One stored entry: the result, the select code that produced it and its flags.
  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic [ALU_SELW-1:0]  sel;
    logic [FLAGW-1:0]     flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational Z/N/P/C flag generator for one ALU result
module alu_flag_gen
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] result_i,
  input  logic             carry_i,
  output logic [FLAGW-1:0] flags_o
);

  // Parity is 1 for an odd number of ones; carry is passed through untouched.
  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_Z] = (result_i == '0);
    flags_o[FLAG_N] = result_i[WIDTH-1];
    flags_o[FLAG_P] = ^result_i;
    flags_o[FLAG_C] = carry_i;
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered result stage with flags and 2-entry skid buffer
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SELW  = ALU_SELW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [SELW-1:0]  in_sel,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [SELW-1:0]  out_sel,
  output logic [FLAGW-1:0] out_flags,
  output logic [15:0]      acc_count
);

  occ_state_e       state_q, state_d;
  alu_entry_t       h_q, h_d;
  alu_entry_t       s_q, s_d;
  logic [15:0]      acc_q, acc_d;
  logic [FLAGW-1:0] new_flags;
  alu_entry_t       new_entry;
  logic             push;
  logic             pop;

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .result_i (in_result),
    .carry_i  (in_carry),
    .flags_o  (new_flags)
  );

  // Handshakes come only from the registered occupancy; ready is also held low during reset.
  assign in_ready  = (state_q != TWO) && !rst;
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign new_entry.result = in_result;
  assign new_entry.sel    = in_sel;
  assign new_entry.flags  = new_flags;

  assign out_result = h_q.result;
  assign out_sel    = h_q.sel;
  assign out_flags  = h_q.flags;
  assign acc_count  = acc_q;

  // Occupancy transitions and head/skid writes; registers only change on capture or skid shift.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          h_d     = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          h_d = new_entry;
        end else if (push) begin
          s_d     = new_entry;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          h_d     = s_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Accepted-transfer counter wraps naturally at 16 bits.
  always_comb begin
    acc_d = acc_q;
    if (push) begin
      acc_d = acc_q + 16'd1;
    end
  end

  // State, storage and counter registers; reset discards any buffered entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      h_q     <= '0;
      s_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard testbench for alu_result_stage
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [2:0]  in_sel;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_sel;
  logic [3:0]  out_flags;
  logic [15:0] acc_count;

  typedef struct {
    logic [15:0] r;
    logic [2:0]  s;
    logic [3:0]  f;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  int          pops  = 0;
  logic [15:0] exp_acc = 16'h0;

  alu_result_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_sel     (in_sel),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_flags  (out_flags),
    .acc_count  (acc_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_flags(input logic [15:0] r, input logic c);
    int ones;
    ones = 0;
    for (int b = 0; b < 16; b++) ones += int'(r[b]);
    return {c, ones[0], r[15], (r == 16'h0000)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [2:0] s,
                       input logic c, input logic ordy);
    in_valid  = v;
    in_result = r;
    in_sel    = s;
    in_carry  = c;
    out_ready = ordy;
  endtask

  // Called #1 after a rising edge: checks handshakes against the model, scores the
  // transfers that the coming edge performs, then advances one clock.
  task automatic tick();
    int   n;
    exp_t e;
    n = sbq.size();
    chk("in_ready", 32'(in_ready), 32'(n < 2));
    chk("out_valid", 32'(out_valid), 32'(n > 0));
    if (out_ready && n > 0) begin
      e = sbq.pop_front();
      pops++;
      chk("out_result", 32'(out_result), 32'(e.r));
      chk("out_sel", 32'(out_sel), 32'(e.s));
      chk("out_flags", 32'(out_flags), 32'(e.f));
    end
    if (in_valid && n < 2) begin
      e.r = in_result;
      e.s = in_sel;
      e.f = model_flags(in_result, in_carry);
      sbq.push_back(e);
      exp_acc = exp_acc + 16'd1;
    end
    @(posedge clk);
    #1;
    chk("acc_count", 32'(acc_count), 32'(exp_acc));
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_result", 32'(out_result), 32'h0);
    chk("rst_out_flags", 32'(out_flags), 32'h0);
    chk("rst_acc", 32'(acc_count), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // 1: single push of zero result
    drive(1'b1, 16'h0000, 3'd3, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_result", 32'(out_result), 32'h0);
    chk("t1_sel", 32'(out_sel), 32'h3);
    chk("t1_flags", 32'(out_flags), 32'h1);
    tick();
    chk("t1_drained", 32'(out_valid), 32'h0);
    chk("t1_acc", 32'(acc_count), 32'h1);

    // 2: back-pressure fills the skid register
    drive(1'b1, 16'h8001, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h00FF, 3'd5, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b0);
    chk("t2_full_ready", 32'(in_ready), 32'h0);
    chk("t2_head", 32'(out_result), 32'h8001);
    chk("t2_head_flags", 32'(out_flags), 32'h2);
    tick();
    tick();
    chk("t2_hold_result", 32'(out_result), 32'h8001);
    chk("t2_hold_flags", 32'(out_flags), 32'h2);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("t2_second", 32'(out_result), 32'h00FF);
    chk("t2_second_flags", 32'(out_flags), 32'h0);
    tick();
    chk("t2_ready_back", 32'(in_ready), 32'h1);
    chk("t2_empty", 32'(out_valid), 32'h0);

    // 3: continuous streaming of 1..100
    p0 = pops;
    for (int i = 1; i <= 100; i++) begin
      drive(1'b1, 16'(i), 3'(i % 8), 1'(i % 2), 1'b1);
      tick();
    end
    chk("t3_pops_during_stream", 32'(pops - p0), 32'd99);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("t3_pops_total", 32'(pops - p0), 32'd100);
    chk("t3_acc", 32'(acc_count), 32'd103);
    chk("t3_sb_empty", 32'(sbq.size()), 32'd0);

    // 4: push and pop on the same edge while in ONE
    drive(1'b1, 16'hAAAA, 3'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h1234, 3'd2, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
    chk("t4_valid", 32'(out_valid), 32'h1);
    chk("t4_result", 32'(out_result), 32'h1234);
    chk("t4_ready", 32'(in_ready), 32'h1);
    tick();
    chk("t4_empty", 32'(out_valid), 32'h0);
    chk("t4_sb_empty", 32'(sbq.size()), 32'd0);

    // 5: counter wrap
    for (int i = 0; i < 70000 && exp_acc != 16'hFFFF; i++) begin
      drive(1'b1, 16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
      tick();
    end
    chk("t5_at_max", 32'(acc_count), 32'hFFFF);
    drive(1'b1, 16'h7FFF, 3'd7, 1'b1, 1'b1);
    tick();
    chk("t5_wrap", 32'(acc_count), 32'h0);
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("t5_sb_empty", 32'(sbq.size()), 32'd0);

    // 6: asynchronous reset while TWO
    drive(1'b1, 16'h1111, 3'd4, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h2222, 3'd6, 1'b1, 1'b0);
    tick();
    chk("t6_full", 32'(in_ready), 32'h0);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'h0);
    chk("t6_async_ready", 32'(in_ready), 32'h0);
    chk("t6_async_result", 32'(out_result), 32'h0);
    chk("t6_async_sel", 32'(out_sel), 32'h0);
    chk("t6_async_flags", 32'(out_flags), 32'h0);
    chk("t6_async_acc", 32'(acc_count), 32'h0);
    sbq.delete();
    exp_acc = 16'h0;
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("t6_held_ready", 32'(in_ready), 32'h0);
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rel_ready", 32'(in_ready), 32'h1);
    chk("t6_rel_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b1, 16'h5A5A, 3'd2, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 3'd0, 1'b0, 1'b1);
    chk("t6_fresh", 32'(out_result), 32'h5A5A);
    tick();
    chk("t6_acc", 32'(acc_count), 32'h1);
    chk("t6_sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
